// File: rtl/ovi_wishbone_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ovi_wishbone_pkg : shared types and constants for the Wishbone arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
package ovi_wishbone_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam int unsigned DEF_N_MST       = 4;
  localparam int unsigned DEF_ADDR_W      = 32;
  localparam int unsigned DEF_DATA_W      = 32;
  localparam int unsigned DEF_TIMEOUT_CYC = 256;

endpackage
`default_nettype wire

// File: rtl/ovi_wb_rr_picker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ovi_wb_rr_picker : combinational round-robin pick, first requester after last
// Revision: 1.0
// ---------------------------------------------------------------------------
module ovi_wb_rr_picker
  import ovi_wishbone_pkg::*;
#(
  parameter int unsigned N = DEF_N_MST
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] last,
  output logic [N-1:0] gnt
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] above;
  logic [N-1:0] req_hi;

  // Requests strictly above the last owner win first; otherwise wrap to the lowest.
  always_comb begin
    above  = ~(last | (last - ONE));
    req_hi = req & above;
    if (|req_hi) begin
      gnt = req_hi & (~req_hi + ONE);
    end else begin
      gnt = req & (~req + ONE);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ovi_wishbone_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ovi_wishbone_arbiter : N-master to 1-slave Wishbone B4 round-robin arbiter
// Optional stall watchdog enabled by defining OVI_WB_ARB_TIMEOUT_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module ovi_wishbone_arbiter
  import ovi_wishbone_pkg::*;
#(
  parameter int unsigned N_MST       = DEF_N_MST,
  parameter int unsigned WB_ADDR_W   = DEF_ADDR_W,
  parameter int unsigned WB_DATA_W   = DEF_DATA_W,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                           wb_clk,
  input  logic                           wb_resetn,
  input  logic [N_MST-1:0]               m_cyc_i,
  input  logic [N_MST-1:0]               m_stb_i,
  input  logic [N_MST-1:0]               m_we_i,
  input  logic [N_MST-1:0]               m_lock_i,
  input  logic [N_MST*WB_ADDR_W-1:0]     m_adr_i,
  input  logic [N_MST*WB_DATA_W-1:0]     m_dat_i,
  input  logic [N_MST*(WB_DATA_W/8)-1:0] m_sel_i,
  input  logic [N_MST*3-1:0]             m_cti_i,
  input  logic [N_MST*2-1:0]             m_bte_i,
  output logic [WB_DATA_W-1:0]           m_dat_o,
  output logic [N_MST-1:0]               m_ack_o,
  output logic [N_MST-1:0]               m_err_o,
  output logic [N_MST-1:0]               m_rty_o,
  output logic                           s_cyc_o,
  output logic                           s_stb_o,
  output logic                           s_we_o,
  output logic                           s_lock_o,
  output logic [WB_ADDR_W-1:0]           s_adr_o,
  output logic [WB_DATA_W-1:0]           s_dat_o,
  output logic [WB_DATA_W/8-1:0]         s_sel_o,
  output logic [2:0]                     s_cti_o,
  output logic [1:0]                     s_bte_o,
  input  logic [WB_DATA_W-1:0]           s_dat_i,
  input  logic                           s_ack_i,
  input  logic                           s_err_i,
  input  logic                           s_rty_i,
  output logic [N_MST-1:0]               gnt_o,
  output logic                           timeout_o
);

  localparam int unsigned SEL_W = WB_DATA_W / 8;
  localparam logic [N_MST-1:0] LAST_RST = {1'b1, {(N_MST-1){1'b0}}};

  arb_state_e state_q, state_d;
  logic [N_MST-1:0] gnt_q, gnt_d;
  logic [N_MST-1:0] last_q, last_d;
  logic [N_MST-1:0] pick;
  logic [N_MST-1:0] own;

  logic                 own_cyc, own_stb, own_we, own_lock;
  logic [WB_ADDR_W-1:0] own_adr;
  logic [WB_DATA_W-1:0] own_dat;
  logic [SEL_W-1:0]     own_sel;
  logic [2:0]           own_cti;
  logic [1:0]           own_bte;
  logic                 resp;
  logic                 release_w;
  logic                 timeout_w;

  ovi_wb_rr_picker #(.N(N_MST)) u_picker (
    .req  (m_cyc_i),
    .last (last_q),
    .gnt  (pick)
  );

  // Masking with reset keeps every routed output quiet while reset is held.
  assign own = gnt_q & {N_MST{wb_resetn}};

  always_comb begin
    own_cyc  = 1'b0;
    own_stb  = 1'b0;
    own_we   = 1'b0;
    own_lock = 1'b0;
    own_adr  = '0;
    own_dat  = '0;
    own_sel  = '0;
    own_cti  = '0;
    own_bte  = '0;
    for (int k = 0; k < N_MST; k++) begin
      if (own[k]) begin
        own_cyc  = own_cyc  | m_cyc_i[k];
        own_stb  = own_stb  | m_stb_i[k];
        own_we   = own_we   | m_we_i[k];
        own_lock = own_lock | m_lock_i[k];
        own_adr  = own_adr  | m_adr_i[k*WB_ADDR_W +: WB_ADDR_W];
        own_dat  = own_dat  | m_dat_i[k*WB_DATA_W +: WB_DATA_W];
        own_sel  = own_sel  | m_sel_i[k*SEL_W +: SEL_W];
        own_cti  = own_cti  | m_cti_i[k*3 +: 3];
        own_bte  = own_bte  | m_bte_i[k*2 +: 2];
      end
    end
  end

  assign resp      = s_ack_i | s_err_i | s_rty_i;
  assign release_w = (state_q == ARB_BUSY) && !own_cyc && !own_lock;

`ifdef OVI_WB_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d     = cnt_q;
    timeout_w = (state_q == ARB_BUSY) && own_stb && !resp && (cnt_q == CNT_MAX);
    if ((state_q != ARB_BUSY) || release_w || timeout_w || resp) begin
      cnt_d = '0;
    end else if (own_stb) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_w = 1'b0;
`endif

  always_ff @(posedge wb_clk) begin
    if (!wb_resetn) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      last_q  <= LAST_RST;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE: begin
        if (|m_cyc_i) begin
          gnt_d   = pick;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (release_w || timeout_w) begin
          last_d  = gnt_q;
          gnt_d   = '0;
          state_d = ARB_IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_comb begin
    s_cyc_o   = own_cyc & ~timeout_w;
    s_stb_o   = own_stb & ~timeout_w;
    s_we_o    = own_we;
    s_lock_o  = own_lock;
    s_adr_o   = own_adr;
    s_dat_o   = own_dat;
    s_sel_o   = own_sel;
    s_cti_o   = own_cti;
    s_bte_o   = own_bte;
    m_dat_o   = s_dat_i;
    m_ack_o   = own & {N_MST{s_ack_i}};
    m_err_o   = own & {N_MST{s_err_i | timeout_w}};
    m_rty_o   = own & {N_MST{s_rty_i}};
    gnt_o     = own;
    timeout_o = timeout_w;
  end

endmodule
`default_nettype wire

// File: tb/tb_ovi_wishbone_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ovi_wishbone_arbiter : directed bench with a cycle-level reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_ovi_wishbone_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic            wb_clk = 1'b0;
  logic            wb_resetn = 1'b0;
  logic [N-1:0]    m_cyc_i = '0, m_stb_i = '0, m_we_i = '0, m_lock_i = '0;
  logic [N*AW-1:0] m_adr_i = '0;
  logic [N*DW-1:0] m_dat_i = '0;
  logic [N*SW-1:0] m_sel_i = '0;
  logic [N*3-1:0]  m_cti_i = '0;
  logic [N*2-1:0]  m_bte_i = '0;
  logic [DW-1:0]   m_dat_o;
  logic [N-1:0]    m_ack_o, m_err_o, m_rty_o, gnt_o;
  logic            s_cyc_o, s_stb_o, s_we_o, s_lock_o, timeout_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [SW-1:0]   s_sel_o;
  logic [2:0]      s_cti_o;
  logic [1:0]      s_bte_o;
  logic [DW-1:0]   s_dat_i = '0;
  logic            s_ack_i = 1'b0, s_err_i = 1'b0, s_rty_i = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  ovi_wishbone_arbiter #(
    .N_MST(N), .WB_ADDR_W(AW), .WB_DATA_W(DW), .TIMEOUT_CYC(TO)
  ) dut (
    .wb_clk(wb_clk), .wb_resetn(wb_resetn),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_lock_i(m_lock_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_lock_o(s_lock_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .gnt_o(gnt_o), .timeout_o(timeout_o)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- reference model: owner index (-1 = nobody), last owner, stall length
  int mdl_owner = -1;
  int mdl_last  = N - 1;
  int mdl_stall = 0;

  function automatic bit mdl_timeout();
`ifdef OVI_WB_ARB_TIMEOUT_EN
    return wb_resetn && (mdl_owner >= 0) && m_stb_i[mdl_owner] &&
           !(s_ack_i || s_err_i || s_rty_i) && (mdl_stall == TO - 1);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge wb_clk) begin
    bit to;
    bit found;
    int c;
    to = mdl_timeout();
    if (!wb_resetn) begin
      mdl_owner = -1;
      mdl_last  = N - 1;
      mdl_stall = 0;
    end else if (mdl_owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        c = (mdl_last + k) % N;
        if (!found && m_cyc_i[c]) begin
          mdl_owner = c;
          found = 1'b1;
        end
      end
      mdl_stall = 0;
    end else if (to || (!m_cyc_i[mdl_owner] && !m_lock_i[mdl_owner])) begin
      mdl_last  = mdl_owner;
      mdl_owner = -1;
      mdl_stall = 0;
    end else if (s_ack_i || s_err_i || s_rty_i) begin
      mdl_stall = 0;
    end else if (m_stb_i[mdl_owner]) begin
      mdl_stall = mdl_stall + 1;
    end
  end

  always @(negedge wb_clk) begin
    int o;
    bit to;
    logic [N-1:0] oh;
    o  = wb_resetn ? mdl_owner : -1;
    to = mdl_timeout();
    oh = '0;
    if (o >= 0) oh[o] = 1'b1;
    check("gnt_o", gnt_o, oh);
    check("timeout_o", timeout_o, to);
    check("m_ack_o", m_ack_o, s_ack_i ? oh : '0);
    check("m_err_o", m_err_o, (s_err_i || to) ? oh : '0);
    check("m_rty_o", m_rty_o, s_rty_i ? oh : '0);
    check("m_dat_o", m_dat_o, s_dat_i);
    if (o >= 0) begin
      check("s_cyc_o", s_cyc_o, m_cyc_i[o] && !to);
      check("s_stb_o", s_stb_o, m_stb_i[o] && !to);
      check("s_we_o", s_we_o, m_we_i[o]);
      check("s_lock_o", s_lock_o, m_lock_i[o]);
      check("s_adr_o", s_adr_o, m_adr_i[o*AW +: AW]);
      check("s_dat_o", s_dat_o, m_dat_i[o*DW +: DW]);
      check("s_sel_o", s_sel_o, m_sel_i[o*SW +: SW]);
      check("s_cti_o", s_cti_o, m_cti_i[o*3 +: 3]);
      check("s_bte_o", s_bte_o, m_bte_i[o*2 +: 2]);
    end else begin
      check("idle_ctl", {s_cyc_o, s_stb_o, s_we_o, s_lock_o}, 4'b0000);
      check("idle_bus", {s_adr_o, s_dat_o}, 64'd0);
      check("idle_misc", {s_sel_o, s_cti_o, s_bte_o}, '0);
    end
  end

  // ---- stimulus helpers (inputs change 1 time unit after the rising edge)
  task automatic tick(input int n = 1);
    repeat (n) @(posedge wb_clk);
    #1;
  endtask

  task automatic drive(input int k, input bit cyc, input bit stb, input bit we,
                       input bit lock, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [2:0] cti);
    m_cyc_i[k]          = cyc;
    m_stb_i[k]          = stb;
    m_we_i[k]           = we;
    m_lock_i[k]         = lock;
    m_adr_i[k*AW +: AW] = adr;
    m_dat_i[k*DW +: DW] = dat;
    m_sel_i[k*SW +: SW] = 4'hF;
    m_cti_i[k*3 +: 3]   = cti;
    m_bte_i[k*2 +: 2]   = 2'b00;
  endtask

  task automatic drop(input int k);
    drive(k, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
  endtask

  function automatic int oh_index(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int order [5];
    int exp_order [5];
    int w;
    exp_order = '{0, 1, 2, 3, 0};

    // 1: reset, including a reset in the middle of m0's cycle
    tick(2);
    wb_resetn = 1'b1;
    drive(0, 1, 1, 1, 0, 32'h0000_0100, 32'h1111_1111, 3'b000);
    tick(2);
    @(negedge wb_clk);
    check("t1_m0_owned", gnt_o, 4'b0001);
    tick;
    wb_resetn = 1'b0;
    s_ack_i   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge wb_clk);
      check("t1_rst_gnt", gnt_o, 4'b0000);
      check("t1_rst_cyc", s_cyc_o, 1'b0);
      check("t1_rst_ack", m_ack_o, 4'b0000);
      tick;
    end
    wb_resetn = 1'b1;
    s_ack_i   = 1'b0;
    drive(1, 1, 1, 0, 0, 32'h0000_0200, 32'h2222_2222, 3'b000);
    tick;
    @(negedge wb_clk);
    check("t1_first_gnt", gnt_o, 4'b0001);
    tick;
    drop(0);
    drop(1);
    tick(2);

    // 2: grant latency and same-cycle ack routing
    drive(2, 1, 1, 0, 0, 32'h1000_0040, 32'h0, 3'b000);
    tick;
    @(negedge wb_clk);
    check("t2_s_cyc", s_cyc_o, 1'b1);
    check("t2_s_adr", s_adr_o, 32'h1000_0040);
    tick;
    s_ack_i = 1'b1;
    @(negedge wb_clk);
    check("t2_m_ack", m_ack_o, 4'b0100);
    tick;
    s_ack_i = 1'b0;
    drop(2);
    tick(2);

    // 3: round robin over four continuously requesting masters
    wb_resetn = 1'b0;
    tick;
    wb_resetn = 1'b1;
    for (int k = 0; k < N; k++)
      drive(k, 1, 1, 1, 0, 32'h2000_0000 + 32'(k * 4), 32'hA000_0000 + 32'(k), 3'b000);
    tick;
    for (int g = 0; g < 5; g++) begin
      w = 0;
      while (gnt_o == '0 && w < 10) begin
        tick;
        w++;
      end
      check("t3_grant_wait", w, 0);
      order[g] = oh_index(gnt_o);
      check("t3_order", order[g], exp_order[g]);
      s_ack_i = 1'b1;
      tick;
      s_ack_i = 1'b0;
      if (g == 4) begin
        for (int k = 0; k < N; k++) drop(k);
      end else if (order[g] >= 0) begin
        drop(order[g]);
      end
      tick;
      check("t3_dead_gnt", gnt_o, 4'b0000);
      check("t3_dead_cyc", s_cyc_o, 1'b0);
      if (g < 4 && order[g] >= 0)
        drive(order[g], 1, 1, 1, 0, 32'h2000_0000 + 32'(order[g] * 4), 32'hB000_0000, 3'b000);
      tick;
    end

    // 4: incrementing burst and LOCK hold (last owner is m0 here)
    drive(1, 1, 1, 1, 0, 32'h3000_0000, 32'hC0DE_0001, 3'b010);
    drive(0, 1, 1, 0, 0, 32'h3100_0000, 32'h0, 3'b000);
    tick;
    for (int b = 0; b < 4; b++) begin
      s_ack_i = 1'b1;
      if (b == 3) m_cti_i[1*3 +: 3] = 3'b111;
      @(negedge wb_clk);
      check("t4_burst_gnt", gnt_o, 4'b0010);
      check("t4_burst_ack", m_ack_o, 4'b0010);
      tick;
    end
    s_ack_i = 1'b0;
    drive(1, 0, 0, 0, 1, 32'h0, 32'h0, 3'b000);
    for (int i = 0; i < 2; i++) begin
      @(negedge wb_clk);
      check("t4_lock_gnt", gnt_o, 4'b0010);
      check("t4_lock_cyc", s_cyc_o, 1'b0);
      check("t4_lock_s_lock", s_lock_o, 1'b1);
      tick;
    end
    drop(1);
    tick;
    @(negedge wb_clk);
    check("t4_dead_gnt", gnt_o, 4'b0000);
    tick;
    @(negedge wb_clk);
    check("t4_m0_gnt", gnt_o, 4'b0001);
    tick;
    drop(0);
    tick(2);

    // 5: err / rty routed to m3 only
    drive(3, 1, 1, 0, 0, 32'h4000_0000, 32'h0, 3'b000);
    tick;
    s_err_i = 1'b1;
    s_dat_i = 32'hDEAD_BEEF;
    @(negedge wb_clk);
    check("t5_err", m_err_o, 4'b1000);
    check("t5_err_ack", m_ack_o, 4'b0000);
    check("t5_err_rty", m_rty_o, 4'b0000);
    check("t5_dat", m_dat_o, 32'hDEAD_BEEF);
    tick;
    s_err_i = 1'b0;
    s_rty_i = 1'b1;
    @(negedge wb_clk);
    check("t5_rty", m_rty_o, 4'b1000);
    check("t5_rty_err", m_err_o, 4'b0000);
    tick;
    s_rty_i = 1'b0;
    drop(3);
    tick(2);

    // 6: silent slave (last owner is m3, so m1 is picked)
    drive(1, 1, 1, 0, 0, 32'h5000_0000, 32'h0, 3'b000);
    tick;
`ifdef OVI_WB_ARB_TIMEOUT_EN
    for (int i = 1; i <= TO; i++) begin
      @(negedge wb_clk);
      if (i < TO) begin
        check("t6_no_timeout", timeout_o, 1'b0);
        tick;
      end else begin
        check("t6_timeout", timeout_o, 1'b1);
        check("t6_err", m_err_o, 4'b0010);
        check("t6_cyc_forced", s_cyc_o, 1'b0);
      end
    end
    tick;
    check("t6_idle_after", gnt_o, 4'b0000);
    drop(1);
    tick(2);
`else
    tick(100);
    @(negedge wb_clk);
    check("t6_still_owned", gnt_o, 4'b0010);
    check("t6_still_cyc", s_cyc_o, 1'b1);
    check("t6_no_timeout", timeout_o, 1'b0);
    tick;
    drop(1);
    tick(2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
